// File: rtl/bcd_updown_display.sv
// Debounced three-button BCD up/down counter driving a multiplexed
// common-anode 7-segment display, with a parallel registered BCD output.

module bcd_btn_db #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DB_CYCLES);

    logic          sync1_q, sync2_q, stable_q, stable_dly_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            if (sync2_q != stable_q) begin
                if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    stable_q <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = stable_q & ~stable_dly_q;
endmodule

module bcd_updown_display #(
    parameter int DIGITS      = 4,
    parameter int DB_CYCLES   = 1000000,
    parameter int SCAN_CYCLES = 25000,
    parameter int WRAP        = 1,
    parameter int LZ_BLANK    = 0
) (
    input  logic                  Clk100Mhz,
    input  logic                  rst_n,
    input  logic                  btnU,
    input  logic                  btnD,
    input  logic                  btnS,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   count
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // press[0]=up, press[1]=down, press[2]=clear
    logic [2:0] btn_raw, press;
    assign btn_raw = {btnS, btnD, btnU};

    bcd_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
        .clk     (Clk100Mhz),
        .rst_n   (rst_n),
        .btn_i   (btn_raw),
        .press_o (press)
    );

    logic [DIGITS-1:0][3:0] cnt_q, cnt_d, inc_v, dec_v;
    logic                   all9, all0;

    always_comb begin
        inc_v = cnt_q;
        dec_v = cnt_q;
        all9  = 1'b1;
        all0  = 1'b1;
        // all9/all0 double as the ripple carry/borrow into digit i
        for (int i = 0; i < DIGITS; i++) begin
            if (all9) inc_v[i] = (cnt_q[i] == 4'd9) ? 4'd0 : cnt_q[i] + 4'd1;
            if (all0) dec_v[i] = (cnt_q[i] == 4'd0) ? 4'd9 : cnt_q[i] - 4'd1;
            all9 = all9 && (cnt_q[i] == 4'd9);
            all0 = all0 && (cnt_q[i] == 4'd0);
        end

        cnt_d = cnt_q;
        if (press[2]) begin
            cnt_d = '0;
        end else if (press[0] && !press[1]) begin
            if (!(all9 && WRAP == 0)) cnt_d = inc_v;
        end else if (press[1] && !press[0]) begin
            if (!(all0 && WRAP == 0)) cnt_d = dec_v;
        end
    end

    logic [SW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d, blank;
    logic [7:0]        seg_q, seg_d;
    logic              slot_end, hi_zero;

    always_comb begin
        blank   = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hi_zero  = hi_zero && (cnt_q[i] == 4'd0);
            blank[i] = (LZ_BLANK != 0) && hi_zero;
        end

        slot_end = (presc_q == SW'(SCAN_CYCLES - 1));
        presc_d  = presc_q + SW'(1);
        idx_d    = idx_q;
        an_d     = an_q;
        seg_d    = seg_q;
        // anode and segments latch together at the slot boundary
        if (slot_end) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
            an_d    = ~(DIGITS'(1) << idx_d);
            seg_d   = blank[idx_d] ? 8'hFF : seg7(cnt_q[idx_d]);
        end
    end

    always_ff @(posedge Clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= 8'hC0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign count = cnt_q;
endmodule
